// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync, vsync, data-enable and pixel/line coordinates for the median-filter pipeline.
// Optional macro VTG_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt_o).
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 10
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           de_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
`ifdef VTG_FRAME_CNT_EN
  output logic           frame_start_o,
  output logic [15:0]    frame_cnt_o
`else
  output logic           frame_start_o
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic           fs_q, fs_d;

  // Wraps use explicit compares so odd totals never rely on counter overflow.
  always_comb begin
    h_cnt_d = h_cnt_q + X_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + Y_W'(1);
    end
    x_d     = h_cnt_q;
    y_d     = v_cnt_q;
    de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vsync_d = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (en_i) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts off the registered pulse, so it steps one cycle after frame_start_o.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fs_q) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
    end else if (en_i) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster (H 8/2/3/3, V 4/1/2/1).
// Honours VTG_FRAME_CNT_EN when the design is built with it.
module tb_video_timing_gen;
  localparam int XW = 11;
  localparam int YW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic          hsync_o, vsync_o, de_o, frame_start_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]   frame_cnt_o;
`endif

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .X_W(XW), .Y_W(YW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .de_o(de_o),
    .x_o(x_o),
    .y_o(y_o),
`ifdef VTG_FRAME_CNT_EN
    .frame_start_o(frame_start_o),
    .frame_cnt_o(frame_cnt_o)
`else
    .frame_start_o(frame_start_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic en;
    int   x;
    int   y;
    int   de;
    int   hs;
    int   vs;
    int   fs;
  } vec_t;

  vec_t vecs[17];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pos   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ex, input int ey,
                         input int ede, input int ehs, input int evs, input int efs);
    chk($sformatf("%s.x", tag), 32'(x_o), ex);
    chk($sformatf("%s.y", tag), 32'(y_o), ey);
    chk($sformatf("%s.de", tag), 32'(de_o), ede);
    chk($sformatf("%s.hsync", tag), 32'(hsync_o), ehs);
    chk($sformatf("%s.vsync", tag), 32'(vsync_o), evs);
    chk($sformatf("%s.frame_start", tag), 32'(frame_start_o), efs);
  endtask

  // Expected outputs for raster position pos, straight from the region boundaries.
  task automatic chk_model();
    int ex, ey;
    ex = pos % 16;
    ey = (pos / 16) % 8;
    chk_out("seq", ex, ey, int'(ex < 8 && ey < 4), int'(ex >= 10 && ex <= 12),
            int'(ey == 5 || ey == 6), int'(ex == 0 && ey == 0));
  endtask

  task automatic step(input logic en);
    en_i = en;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic adv();
    step(1'b1);
    pos++;
    chk_model();
  endtask

  task automatic run_to(input int tx, input int ty);
    for (int i = 0; i < 200; i++) begin
      if (pos % 16 == tx && (pos / 16) % 8 == ty) return;
      adv();
    end
    chk("run_to_bound", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fsn, vsn, den, run, maxrun;

    vecs[0]  = '{1'b1,  0, 0, 1, 0, 0, 1};
    vecs[1]  = '{1'b1,  1, 0, 1, 0, 0, 0};
    vecs[2]  = '{1'b1,  2, 0, 1, 0, 0, 0};
    vecs[3]  = '{1'b1,  3, 0, 1, 0, 0, 0};
    vecs[4]  = '{1'b1,  4, 0, 1, 0, 0, 0};
    vecs[5]  = '{1'b1,  5, 0, 1, 0, 0, 0};
    vecs[6]  = '{1'b1,  6, 0, 1, 0, 0, 0};
    vecs[7]  = '{1'b1,  7, 0, 1, 0, 0, 0};
    vecs[8]  = '{1'b1,  8, 0, 0, 0, 0, 0};
    vecs[9]  = '{1'b1,  9, 0, 0, 0, 0, 0};
    vecs[10] = '{1'b1, 10, 0, 0, 1, 0, 0};
    vecs[11] = '{1'b1, 11, 0, 0, 1, 0, 0};
    vecs[12] = '{1'b1, 12, 0, 0, 1, 0, 0};
    vecs[13] = '{1'b1, 13, 0, 0, 0, 0, 0};
    vecs[14] = '{1'b1, 14, 0, 0, 0, 0, 0};
    vecs[15] = '{1'b1, 15, 0, 0, 0, 0, 0};
    vecs[16] = '{1'b1,  0, 1, 1, 0, 0, 0};

    rst_ni = 1'b0;
    en_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    chk_out("reset", 0, 0, 0, 0, 0, 0);
`ifdef VTG_FRAME_CNT_EN
    chk("reset.frame_cnt", 32'(frame_cnt_o), 0);
`endif
    rst_ni = 1'b1;

    // First line plus the step into line 1.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en);
      $display("vec %0d: x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b", i, x_o, y_o,
               de_o, hsync_o, vsync_o, frame_start_o);
      chk_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de,
              vecs[i].hs, vecs[i].vs, vecs[i].fs);
    end
    pos = 16;

    // Whole second frame: per-frame pulse, vsync and de tallies.
    run_to(15, 7);
    fsn = 0; vsn = 0; den = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 128; i++) begin
      adv();
      fsn += int'(frame_start_o);
      den += int'(de_o);
      if (vsync_o) begin
        vsn++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    $display("frame: fs=%0d vsync_cycles=%0d vsync_run=%0d de_cycles=%0d", fsn, vsn, maxrun, den);
    chk("frame.fs_pulses", fsn, 1);
    chk("frame.vsync_cycles", vsn, 32);
    chk("frame.vsync_run", maxrun, 32);
    chk("frame.de_cycles", den, 32);
    step(1'b1);
    pos++;
    chk_out("frame3_start", 0, 0, 1, 0, 0, 1);

    // Enable drop mid-line.
    run_to(6, 2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      $display("hold %0d: x=%0d y=%0d de=%0b", i, x_o, y_o, de_o);
      chk_out("hold", 6, 2, 1, 0, 0, 0);
`ifdef VTG_FRAME_CNT_EN
      chk("hold.frame_cnt", 32'(frame_cnt_o), 3);
`endif
    end
    step(1'b1);
    pos++;
    chk_out("resume", 7, 2, 1, 0, 0, 0);

    // Line and frame wrap boundaries.
    run_to(15, 3);
    step(1'b1);
    pos++;
    chk_out("wrap_line", 0, 4, 0, 0, 0, 0);
    run_to(15, 7);
    step(1'b1);
    pos++;
    chk_out("wrap_frame", 0, 0, 1, 0, 0, 1);

    // Asynchronous reset inside hsync and vsync.
    run_to(12, 6);
    chk_out("pre_rst", 12, 6, 0, 1, 1, 0);
    #1;
    rst_ni = 1'b0;
    #1;
    $display("async reset: x=%0d y=%0d hs=%0b vs=%0b", x_o, y_o, hsync_o, vsync_o);
    chk_out("async_rst", 0, 0, 0, 0, 0, 0);
`ifdef VTG_FRAME_CNT_EN
    chk("async_rst.frame_cnt", 32'(frame_cnt_o), 0);
`endif
    @(posedge clk_i);
    @(negedge clk_i);
    chk_out("rst_hold", 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    step(1'b1);
    pos = 0;
    chk_out("restart", 0, 0, 1, 0, 0, 1);

    // Three frames after restart; frame counter steps 0,1,2,3.
`ifdef VTG_FRAME_CNT_EN
    chk("fcnt.f0", 32'(frame_cnt_o), 0);
`endif
    adv();
`ifdef VTG_FRAME_CNT_EN
    chk("fcnt.f0_next", 32'(frame_cnt_o), 1);
`endif
    run_to(0, 0);
`ifdef VTG_FRAME_CNT_EN
    chk("fcnt.f1", 32'(frame_cnt_o), 1);
`endif
    adv();
`ifdef VTG_FRAME_CNT_EN
    chk("fcnt.f1_next", 32'(frame_cnt_o), 2);
`endif
    run_to(0, 0);
`ifdef VTG_FRAME_CNT_EN
    chk("fcnt.f2", 32'(frame_cnt_o), 2);
`endif
    adv();
`ifdef VTG_FRAME_CNT_EN
    chk("fcnt.f2_next", 32'(frame_cnt_o), 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
